// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg
//   Shared definitions for the microprogram sequencer: the opcode width and
//   the opcode encodings. The microcode assembler checks reuse the same
//   values, so the encodings must never be renumbered.
package micro_sequencer_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] SEQ_CONT   = 4'd0;
  localparam logic [OP_W-1:0] SEQ_JUMP   = 4'd1;
  localparam logic [OP_W-1:0] SEQ_CJMP   = 4'd2;
  localparam logic [OP_W-1:0] SEQ_CALL   = 4'd3;
  localparam logic [OP_W-1:0] SEQ_CCALL  = 4'd4;
  localparam logic [OP_W-1:0] SEQ_RET    = 4'd5;
  localparam logic [OP_W-1:0] SEQ_CRET   = 4'd6;
  localparam logic [OP_W-1:0] SEQ_LDCT   = 4'd7;
  localparam logic [OP_W-1:0] SEQ_LOOP   = 4'd8;
  localparam logic [OP_W-1:0] SEQ_PUSHLD = 4'd9;
  localparam logic [OP_W-1:0] SEQ_RPT    = 4'd10;
  localparam logic [OP_W-1:0] SEQ_CASE   = 4'd11;
  localparam logic [OP_W-1:0] SEQ_SEQRST = 4'd12;

endpackage

// File: rtl/micro_seq_stack.sv
// micro_seq_stack
//   Parametrised LIFO holding subroutine return addresses.
//   Ports:
//     clock, reset   rising-edge clock, asynchronous active-high reset
//     clear          empty the stack (sp <= 0), contents left in place
//     push           write din on top (ignored when full)
//     pop            drop top entry (ignored when empty)
//     peek           top entry is being read without a pop
//     din            value to push
//     tos            current top of stack (0 when empty)
//     full, empty    sp == DEPTH / sp == 0
//     err_ovf        push attempted while full (combinational)
//     err_unf        pop or peek attempted while empty (combinational)
//   push and pop are never asserted together by the sequencer.
module micro_seq_stack #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              peek,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] tos,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  // sp counts entries, so the next free slot is sp and the top is sp-1.
  // Both indices are only used when the matching guard (not full / not
  // empty) holds, so truncation at the boundaries is harmless.
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign tos     = empty ? '0 : mem[top_idx];
  assign err_ovf = push & full;
  assign err_unf = (pop | peek) & empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Microprogram sequencer sitting between the pipeline register and the
//   microcode ROM address input. y is the ROM address of the next microword.
//   Ports:
//     clock, reset   rising-edge clock, asynchronous active-high reset
//     op             sequencer opcode (see micro_sequencer_pkg)
//     d_in           branch address / counter load value
//     cond_sel       selects one bit of cond_vec
//     cond_vec       condition inputs
//     cond_pol       1 inverts the selected condition
//     case_or        OR-ed into the low bits of d_in on CASE
//     hold           freeze all sequencer state for this clock
//     y              next microaddress (combinational, 0 during reset)
//     stack_full     subroutine stack full
//     stack_empty    subroutine stack empty
//     stack_err      sticky overflow/underflow, cleared by reset or SEQRST
//     cnt_zero       loop counter is zero
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 11,
  parameter int NUM_COND    = 8,
  parameter int CASE_W      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [OP_W-1:0]             op,
  input  logic [ADDR_W-1:0]           d_in,
  input  logic [$clog2(NUM_COND)-1:0] cond_sel,
  input  logic [NUM_COND-1:0]         cond_vec,
  input  logic                        cond_pol,
  input  logic [CASE_W-1:0]           case_or,
  input  logic                        hold,
  output logic [ADDR_W-1:0]           y,
  output logic                        stack_full,
  output logic                        stack_empty,
  output logic                        stack_err,
  output logic                        cnt_zero
);

  logic [ADDR_W-1:0] upc;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;

  logic [ADDR_W-1:0] y_nxt;
  logic [ADDR_W-1:0] tos;
  logic [CNT_W-1:0]  cnt_load;
  logic              pass;
  logic              do_push;
  logic              do_pop;
  logic              do_peek;
  logic              do_ld;
  logic              do_dec;
  logic              do_seqrst;
  logic              err_ovf;
  logic              err_unf;

  assign pass     = cond_vec[cond_sel] ^ cond_pol;
  assign cnt_zero = (cnt == '0);
  assign cnt_load = CNT_W'(d_in);

  // Next-address mux and the side effects requested for the coming edge.
  // Any TOS read on an empty stack falls back to upc.
  always_comb begin
    y_nxt     = upc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_peek   = 1'b0;
    do_ld     = 1'b0;
    do_dec    = 1'b0;
    do_seqrst = 1'b0;
    case (op)
      SEQ_JUMP: y_nxt = d_in;
      SEQ_CJMP: if (pass) y_nxt = d_in;
      SEQ_CALL: begin
        y_nxt   = d_in;
        do_push = 1'b1;
      end
      SEQ_CCALL: begin
        if (pass) begin
          y_nxt   = d_in;
          do_push = 1'b1;
        end
      end
      SEQ_RET: begin
        do_pop = 1'b1;
        if (!stack_empty) y_nxt = tos;
      end
      SEQ_CRET: begin
        if (pass) begin
          do_pop = 1'b1;
          if (!stack_empty) y_nxt = tos;
        end
      end
      SEQ_LDCT: do_ld = 1'b1;
      SEQ_LOOP: begin
        if (!cnt_zero) begin
          y_nxt  = d_in;
          do_dec = 1'b1;
        end
      end
      SEQ_PUSHLD: begin
        do_push = 1'b1;
        do_ld   = 1'b1;
      end
      SEQ_RPT: begin
        if (!cnt_zero) begin
          do_peek = 1'b1;
          do_dec  = 1'b1;
          if (!stack_empty) y_nxt = tos;
        end else begin
          do_pop = 1'b1;
        end
      end
      SEQ_CASE:   y_nxt = d_in | ADDR_W'(case_or);
      SEQ_SEQRST: begin
        y_nxt     = '0;
        do_seqrst = 1'b1;
      end
      default: y_nxt = upc;
    endcase
  end

  assign y         = reset ? '0 : y_nxt;
  assign stack_err = err_q;

  // Stack requests are gated by hold so the LIFO freezes with the rest.
  micro_seq_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clock   (clock),
    .reset   (reset),
    .clear   (do_seqrst & ~hold),
    .push    (do_push & ~hold),
    .pop     (do_pop & ~hold),
    .peek    (do_peek & ~hold),
    .din     (upc),
    .tos     (tos),
    .full    (stack_full),
    .empty   (stack_empty),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (!hold) begin
      upc <= y_nxt + ADDR_W'(1);
      if (do_ld) begin
        cnt <= cnt_load;
      end else if (do_dec) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (do_seqrst) begin
        err_q <= 1'b0;
      end else if (err_ovf || err_unf) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//   Directed bench for micro_sequencer with default parameters
//   (ADDR_W 11, STACK_DEPTH 4, CNT_W 11, NUM_COND 8, CASE_W 4).
//   Inputs change 1 time unit after a rising edge; y and flags are sampled
//   on the falling edge or just after a rising edge.
module tb_micro_sequencer;
  import micro_sequencer_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  op;
  logic [10:0] d_in;
  logic [2:0]  cond_sel;
  logic [7:0]  cond_vec;
  logic        cond_pol;
  logic [3:0]  case_or;
  logic        hold;
  logic [10:0] y;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;
  logic        cnt_zero;

  int n_cmp = 0;
  int n_err = 0;

  micro_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .op          (op),
    .d_in        (d_in),
    .cond_sel    (cond_sel),
    .cond_vec    (cond_vec),
    .cond_pol    (cond_pol),
    .case_or     (case_or),
    .hold        (hold),
    .y           (y),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err),
    .cnt_zero    (cnt_zero)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic drive(input logic [3:0] o, input logic [10:0] d);
    op   = o;
    d_in = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic test_reset();
    // Build up state: cnt = 5, two return addresses, upc = 0x123.
    drive(SEQ_LDCT, 11'd5);     tick();
    drive(SEQ_CALL, 11'h010);   tick();
    drive(SEQ_CALL, 11'h122);   tick();
    drive(SEQ_CONT, 11'h000);   sample();
    n_cmp++; if (y !== 11'h123) begin n_err++; $display("FAIL pre_reset_y: got %h expected %h", y, 11'h123); end
    n_cmp++; if (stack_empty !== 1'b0 || cnt_zero !== 1'b0) begin n_err++; $display("FAIL pre_reset_flags: got empty %b cnt_zero %b expected 0 0", stack_empty, cnt_zero); end
    tick();
    // Assert reset mid-cycle with a JUMP on the bus: y must still read 0.
    drive(SEQ_JUMP, 11'h3FF);
    reset = 1'b1;
    #1;
    n_cmp++; if (y !== 11'h000) begin n_err++; $display("FAIL reset_y: got %h expected %h", y, 11'h000); end
    n_cmp++; if ({stack_empty, stack_full, cnt_zero, stack_err} !== 4'b1010) begin n_err++; $display("FAIL reset_flags: got empty/full/cz/err %b expected 1010", {stack_empty, stack_full, cnt_zero, stack_err}); end
    tick();
    drive(SEQ_CONT, 11'h000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_cmp++; if (y !== 11'(i)) begin n_err++; $display("FAIL post_reset_cont: got %h expected %h", y, 11'(i)); end
      tick();
    end
  endtask

  task automatic test_call_ret();
    drive(SEQ_JUMP, 11'h050);   tick();   // CALL word lives at 0x050, upc 0x051
    drive(SEQ_CALL, 11'h200);   sample();
    n_cmp++; if (y !== 11'h200) begin n_err++; $display("FAIL call_y: got %h expected %h", y, 11'h200); end
    tick();
    drive(SEQ_CONT, 11'h000);   tick();
    drive(SEQ_RET, 11'h000);    sample();
    n_cmp++; if (y !== 11'h051) begin n_err++; $display("FAIL ret_y: got %h expected %h", y, 11'h051); end
    tick();
    n_cmp++; if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin n_err++; $display("FAIL ret_empty: got empty %b err %b expected 1 0", stack_empty, stack_err); end
  endtask

  task automatic test_stack_overflow();
    logic [10:0] ret_exp [4];
    ret_exp[0] = 11'h121; ret_exp[1] = 11'h111; ret_exp[2] = 11'h101; ret_exp[3] = 11'h001;
    drive(SEQ_SEQRST, 11'h000); sample();
    n_cmp++; if (y !== 11'h000) begin n_err++; $display("FAIL seqrst_y: got %h expected %h", y, 11'h000); end
    tick();                                       // upc = 1
    for (int i = 0; i < 4; i++) begin
      drive(SEQ_CALL, 11'h100 + 11'(i * 16)); tick();
    end
    n_cmp++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin n_err++; $display("FAIL full_after_4: got full %b err %b expected 1 0", stack_full, stack_err); end
    drive(SEQ_CALL, 11'h140);   sample();
    n_cmp++; if (y !== 11'h140) begin n_err++; $display("FAIL ovf_branch_y: got %h expected %h", y, 11'h140); end
    tick();
    n_cmp++; if (stack_err !== 1'b1 || stack_full !== 1'b1) begin n_err++; $display("FAIL ovf_err: got err %b full %b expected 1 1", stack_err, stack_full); end
    for (int i = 0; i < 4; i++) begin
      drive(SEQ_RET, 11'h000);  sample();
      n_cmp++; if (y !== ret_exp[i]) begin n_err++; $display("FAIL lifo_ret%0d: got %h expected %h", i, y, ret_exp[i]); end
      tick();
    end
    // upc = 0x002 after the last good RET; the fifth RET underflows.
    drive(SEQ_RET, 11'h000);    sample();
    n_cmp++; if (y !== 11'h002) begin n_err++; $display("FAIL unf_ret_y: got %h expected %h", y, 11'h002); end
    tick();
    n_cmp++; if (stack_err !== 1'b1 || stack_empty !== 1'b1) begin n_err++; $display("FAIL unf_err: got err %b empty %b expected 1 1", stack_err, stack_empty); end
    drive(SEQ_SEQRST, 11'h000); tick();
    n_cmp++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL seqrst_clears_err: got %b expected 0", stack_err); end
  endtask

  task automatic test_loop();
    drive(SEQ_LDCT, 11'd3);     tick();           // upc = 2, cnt = 3
    n_cmp++; if (cnt_zero !== 1'b0) begin n_err++; $display("FAIL ldct_cnt_zero: got %b expected 0", cnt_zero); end
    for (int i = 0; i < 3; i++) begin
      drive(SEQ_LOOP, 11'h040); sample();
      n_cmp++; if (y !== 11'h040) begin n_err++; $display("FAIL loop_taken%0d: got %h expected %h", i, y, 11'h040); end
      tick();
    end
    drive(SEQ_LOOP, 11'h040);   sample();
    n_cmp++; if (y !== 11'h041 || cnt_zero !== 1'b1) begin n_err++; $display("FAIL loop_fall: got y %h cz %b expected 041 1", y, cnt_zero); end
    tick();                                       // upc = 0x042
  endtask

  task automatic test_cond();
    cond_sel = 3'd2;
    cond_vec = 8'b0000_0100;
    cond_pol = 1'b0;
    drive(SEQ_CJMP, 11'h300);   sample();
    n_cmp++; if (y !== 11'h300) begin n_err++; $display("FAIL cjmp_pass: got %h expected %h", y, 11'h300); end
    tick();                                       // upc = 0x301
    cond_pol = 1'b1;
    drive(SEQ_CJMP, 11'h300);   sample();
    n_cmp++; if (y !== 11'h301) begin n_err++; $display("FAIL cjmp_fail: got %h expected %h", y, 11'h301); end
    tick();                                       // upc = 0x302
    cond_pol = 1'b0;
    drive(SEQ_CCALL, 11'h310);  sample();
    n_cmp++; if (y !== 11'h310) begin n_err++; $display("FAIL ccall_pass: got %h expected %h", y, 11'h310); end
    tick();                                       // push 0x302, upc = 0x311
    cond_pol = 1'b1;
    drive(SEQ_CRET, 11'h000);   sample();
    n_cmp++; if (y !== 11'h311) begin n_err++; $display("FAIL cret_fail: got %h expected %h", y, 11'h311); end
    tick();                                       // upc = 0x312
    cond_pol = 1'b0;
    drive(SEQ_CRET, 11'h000);   sample();
    n_cmp++; if (y !== 11'h302) begin n_err++; $display("FAIL cret_pass: got %h expected %h", y, 11'h302); end
    tick();                                       // upc = 0x303
    n_cmp++; if (stack_empty !== 1'b1) begin n_err++; $display("FAIL cret_pop: got empty %b expected 1", stack_empty); end
  endtask

  task automatic test_case_hold();
    case_or = 4'hA;
    drive(SEQ_CASE, 11'h0F0);   sample();
    n_cmp++; if (y !== 11'h0FA) begin n_err++; $display("FAIL case_y: got %h expected %h", y, 11'h0FA); end
    tick();                                       // upc = 0x0FB
    drive(SEQ_LDCT, 11'd7);     tick();           // upc = 0x0FC, cnt = 7
    drive(SEQ_CALL, 11'h1F0);   tick();           // push 0x0FC, upc = 0x1F1
    hold = 1'b1;
    drive(SEQ_CONT, 11'h000);   tick();
    drive(SEQ_RET, 11'h000);    sample();
    n_cmp++; if (y !== 11'h0FC) begin n_err++; $display("FAIL hold_y_driven: got %h expected %h", y, 11'h0FC); end
    tick();
    drive(SEQ_LDCT, 11'h000);   tick();
    hold = 1'b0;
    drive(SEQ_CONT, 11'h000);   sample();
    n_cmp++; if (y !== 11'h1F1) begin n_err++; $display("FAIL hold_upc: got %h expected %h", y, 11'h1F1); end
    n_cmp++; if (stack_empty !== 1'b0 || cnt_zero !== 1'b0) begin n_err++; $display("FAIL hold_sp_cnt: got empty %b cz %b expected 0 0", stack_empty, cnt_zero); end
    tick();
    drive(SEQ_RET, 11'h000);    sample();
    n_cmp++; if (y !== 11'h0FC) begin n_err++; $display("FAIL hold_tos: got %h expected %h", y, 11'h0FC); end
    tick();
  endtask

  task automatic test_wrap();
    drive(SEQ_JUMP, 11'h7FE);   tick();           // upc = 0x7FF
    drive(SEQ_CONT, 11'h000);   sample();
    n_cmp++; if (y !== 11'h7FF) begin n_err++; $display("FAIL wrap_top: got %h expected %h", y, 11'h7FF); end
    tick();
    sample();
    n_cmp++; if (y !== 11'h000) begin n_err++; $display("FAIL wrap_zero: got %h expected %h", y, 11'h000); end
    tick();                                       // upc = 1
  endtask

  task automatic test_back_to_back();
    // PUSHLD then RPT: repeat the pushed word twice, then fall through and pop.
    drive(SEQ_PUSHLD, 11'd2);   sample();
    n_cmp++; if (y !== 11'h001) begin n_err++; $display("FAIL pushld_y: got %h expected %h", y, 11'h001); end
    tick();                                       // push 1, cnt = 2, upc = 2
    for (int i = 0; i < 2; i++) begin
      drive(SEQ_RPT, 11'h000);  sample();
      n_cmp++; if (y !== 11'h001) begin n_err++; $display("FAIL rpt_taken%0d: got %h expected %h", i, y, 11'h001); end
      tick();
    end
    drive(SEQ_RPT, 11'h000);    sample();
    n_cmp++; if (y !== 11'h002) begin n_err++; $display("FAIL rpt_fall: got %h expected %h", y, 11'h002); end
    tick();
    n_cmp++; if ({stack_empty, cnt_zero, stack_err} !== 3'b110) begin n_err++; $display("FAIL rpt_end_flags: got empty/cz/err %b expected 110", {stack_empty, cnt_zero, stack_err}); end
  endtask

  initial begin
    reset    = 1'b1;
    op       = SEQ_CONT;
    d_in     = '0;
    cond_sel = '0;
    cond_vec = '0;
    cond_pol = 1'b0;
    case_or  = '0;
    hold     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_call_ret();
    test_stack_overflow();
    test_loop();
    test_cond();
    test_case_hold();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
